topk_merge_ctrl: RTL and testbench
==================================

TOPK_MERGE_CTRL -- requirements
Module: topk_merge_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 11, distance width.
REQ-002 SHALL have parameter IDX_WIDTH, default 9, candidate index width.
REQ-003 SHALL have parameter NB_WIDTH, default 4, batch-count width.
REQ-004 SHALL have parameter TIMEOUT, default 64, watchdog limit in cycles.
REQ-005 SHALL use one clock and a synchronous, active-high reset, as the ports below define.
REQ-006 SHALL provide ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  query start pulse.
- num_batches  in  NB_WIDTH  number of 4-candidate batches in the query.
- busy  out  1  high whenever the state is not IDLE.
- cand_valid  in  1  candidate batch valid.
- cand_ready  out  1  controller accepts a batch.
- cand_data_k, k=0..3  in  DATA_WIDTH  candidate distances.
- cand_idx_k, k=0..3  in  IDX_WIDTH  candidate indices.
- sort_valid_in  out  1  drives sorter valid_in.
- sort_data_in_k / sort_idx_in_k, k=0..7  out  DATA_WIDTH / IDX_WIDTH  sorter lanes.
- sort_valid_out  in  1  sorter result valid.
- sort_data_out_k / sort_idx_out_k, k=0..3  in  DATA_WIDTH / IDX_WIDTH  sorter top-4, ascending.
- res_valid  out  1  one-cycle result pulse.
- res_data_k / res_idx_k, k=0..3  out  DATA_WIDTH / IDX_WIDTH  final top-4, ascending.
- err_timeout  out  1  sticky watchdog error (macro only).

Function
REQ-007 SHALL implement an FSM with states IDLE, LOAD, WAIT and DONE.
REQ-008 In IDLE, start=1 SHALL latch num_batches into the remaining counter, set all 4 best entries to data all-ones and idx 0, and move to LOAD; if num_batches=0, it SHALL move to DONE instead.
REQ-009 start SHALL be ignored outside IDLE.
REQ-010 cand_ready SHALL equal (state==LOAD); a batch transfers when cand_valid and cand_ready are both high in the same cycle.
REQ-011 On transfer, the next cycle SHALL register sort_valid_in=1 for exactly one cycle, with lanes 0..3 carrying the running best and lanes 4..7 carrying cand 0..3; the FSM SHALL move to WAIT.
REQ-012 Sorter lane outputs SHALL hold their last value when sort_valid_in=0.
REQ-013 In WAIT, sort_valid_out=1 SHALL load sort_*_out_0..3 into the best registers and decrement remaining; the FSM SHALL move to DONE if the new remaining is 0, else to LOAD.
REQ-014 sort_valid_out outside WAIT SHALL be ignored.
REQ-015 In DONE, res_valid SHALL be 1 for one cycle, res_* SHALL present the best registers, and the FSM SHALL return to IDLE.
REQ-016 res_* SHALL hold their value until the next DONE.
REQ-017 With no stalls, query latency SHALL be num_batches×(sorter latency + 2) + 2 cycles from start to res_valid.
REQ-018 A new start SHALL be accepted one cycle after res_valid (back-to-back).
REQ-019 Data ordering and tie-breaking SHALL be inherited unmodified from the sorter; the block SHALL perform no arithmetic on distances.

Reset
REQ-020 rst=1 SHALL force state IDLE, busy=0, cand_ready=0, sort_valid_in=0, res_valid=0, err_timeout=0, remaining=0, best and res data to all-ones, and best and res idx to 0.
REQ-021 rst asserted mid-query SHALL abandon the query without a res_valid pulse.
REQ-022 Sorter results arriving after that reset SHALL be ignored per REQ-014.

Configuration
REQ-023 With macro TOPK_MERGE_TIMEOUT_EN defined, a counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-024 With TOPK_MERGE_TIMEOUT_EN defined, reaching TIMEOUT without sort_valid_out SHALL set err_timeout (sticky until rst) and move the FSM to IDLE with no res_valid.
REQ-025 Without TOPK_MERGE_TIMEOUT_EN, err_timeout SHALL be tied to 0, no counter SHALL exist, and WAIT SHALL wait indefinitely.

Verification
REQ-026 Single batch: start with num_batches=1; batch data {3,20,124,826}, idx {1,2,4,7} -> res data {3,20,124,826}, idx {1,2,4,7}.
REQ-027 Two batches: batch 1 as in REQ-026, then data {0,125,83,283}, idx {0,5,3,6} -> res data {0,3,20,83}, idx {0,1,2,3}; exactly 2 sort_valid_in pulses.
REQ-028 num_batches=0 -> res_valid 2 cycles after start; data all 0x7FF, idx 0; no sort_valid_in pulse.
REQ-029 cand_valid held low for 10 cycles in LOAD, then start pulsed mid-query -> no sorter activity, start ignored, the result is correct once the batch arrives.
REQ-030 rst asserted in WAIT, then a late sort_valid_out -> outputs match reset values, no res_valid; the next query is correct.
REQ-031 With TOPK_MERGE_TIMEOUT_EN defined, sort_valid_out withheld -> err_timeout=1 exactly TIMEOUT cycles after entering WAIT, busy=0, and err_timeout stays 1 until rst.

Source files
------------

// File: rtl/topk_merge_ctrl_if.sv
// Bundle of query control, candidate batch, sorter lane and result signals
// shared between topk_merge_ctrl (slave) and its environment (master).
interface topk_merge_ctrl_if #(
  parameter int DATA_WIDTH = 11,
  parameter int IDX_WIDTH  = 9,
  parameter int NB_WIDTH   = 4
);
  logic                  start;
  logic [NB_WIDTH-1:0]   num_batches;
  logic                  busy;
  logic                  cand_valid;
  logic                  cand_ready;
  logic [DATA_WIDTH-1:0] cand_data     [4];
  logic [IDX_WIDTH-1:0]  cand_idx      [4];
  logic                  sort_valid_in;
  logic [DATA_WIDTH-1:0] sort_data_in  [8];
  logic [IDX_WIDTH-1:0]  sort_idx_in   [8];
  logic                  sort_valid_out;
  logic [DATA_WIDTH-1:0] sort_data_out [4];
  logic [IDX_WIDTH-1:0]  sort_idx_out  [4];
  logic                  res_valid;
  logic [DATA_WIDTH-1:0] res_data      [4];
  logic [IDX_WIDTH-1:0]  res_idx       [4];
  logic                  err_timeout;

  modport slave (
    input  start, num_batches, cand_valid, cand_data, cand_idx,
           sort_valid_out, sort_data_out, sort_idx_out,
    output busy, cand_ready, sort_valid_in, sort_data_in, sort_idx_in,
           res_valid, res_data, res_idx, err_timeout
  );

  modport master (
    output start, num_batches, cand_valid, cand_data, cand_idx,
           sort_valid_out, sort_data_out, sort_idx_out,
    input  busy, cand_ready, sort_valid_in, sort_data_in, sort_idx_in,
           res_valid, res_data, res_idx, err_timeout
  );
endinterface

// File: rtl/topk_merge_ctrl.sv
// Top-4 merge controller: feeds running best + 4 candidates to an external 8-lane sorter per batch.
// Optional WAIT watchdog enabled by defining TOPK_MERGE_TIMEOUT_EN.
module topk_merge_ctrl #(
  parameter int DATA_WIDTH = 11,
  parameter int IDX_WIDTH  = 9,
  parameter int NB_WIDTH   = 4,
  parameter int TIMEOUT    = 64
) (
  input logic              clk,
  input logic              rst,
  topk_merge_ctrl_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start
  // LOAD  | cand_ready high, waiting for a candidate batch
  // WAIT  | batch issued to sorter, waiting for its top-4
  // DONE  | publish best registers as the result
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [NB_WIDTH-1:0]   remaining;
  logic [DATA_WIDTH-1:0] best_data [4];
  logic [IDX_WIDTH-1:0]  best_idx  [4];
  logic                  timeout_hit;

`ifdef TOPK_MERGE_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  assign timeout_hit = (state_q == WAIT) && !bus.sort_valid_out && (wd_cnt == WD_LAST);

  // Counter sits at zero outside WAIT, so it starts from zero on every WAIT entry
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q != WAIT) wd_cnt <= '0;
      else                 wd_cnt <= wd_cnt + WD_W'(1);
      if (timeout_hit)     err_q  <= 1'b1;
    end
  end

  assign bus.err_timeout = err_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.err_timeout = 1'b0 && (TIMEOUT > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.busy       = (state_q != IDLE);
    bus.cand_ready = (state_q == LOAD);
    unique case (state_q)
      IDLE: if (bus.start) state_d = (bus.num_batches == '0) ? DONE : LOAD;
      LOAD: if (bus.cand_valid) state_d = WAIT;
      WAIT: begin
        if (bus.sort_valid_out) state_d = (remaining == NB_WIDTH'(1)) ? DONE : LOAD;
        else if (timeout_hit)   state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining         <= '0;
      bus.sort_valid_in <= 1'b0;
      bus.res_valid     <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        best_data[k]    <= '1;
        best_idx[k]     <= '0;
        bus.res_data[k] <= '1;
        bus.res_idx[k]  <= '0;
      end
      for (int k = 0; k < 8; k++) begin
        bus.sort_data_in[k] <= '0;
        bus.sort_idx_in[k]  <= '0;
      end
    end else begin
      bus.sort_valid_in <= 1'b0;
      bus.res_valid     <= 1'b0;
      unique case (state_q)
        IDLE: if (bus.start) begin
          remaining <= bus.num_batches;
          for (int k = 0; k < 4; k++) begin
            best_data[k] <= '1;
            best_idx[k]  <= '0;
          end
        end
        LOAD: if (bus.cand_valid) begin
          bus.sort_valid_in <= 1'b1;
          for (int k = 0; k < 4; k++) begin
            bus.sort_data_in[k]     <= best_data[k];
            bus.sort_idx_in[k]      <= best_idx[k];
            bus.sort_data_in[k + 4] <= bus.cand_data[k];
            bus.sort_idx_in[k + 4]  <= bus.cand_idx[k];
          end
        end
        WAIT: if (bus.sort_valid_out) begin
          remaining <= remaining - NB_WIDTH'(1);
          for (int k = 0; k < 4; k++) begin
            best_data[k] <= bus.sort_data_out[k];
            best_idx[k]  <= bus.sort_idx_out[k];
          end
        end
        DONE: begin
          bus.res_valid <= 1'b1;
          for (int k = 0; k < 4; k++) begin
            bus.res_data[k] <= best_data[k];
            bus.res_idx[k]  <= best_idx[k];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_topk_merge_ctrl.sv
// Directed bench for topk_merge_ctrl with a 2-cycle behavioural 8-lane sorter.
module tb_topk_merge_ctrl;
  localparam int DW  = 11;
  localparam int IW  = 9;
  localparam int NBW = 4;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  topk_merge_ctrl_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW), .NB_WIDTH(NBW)) bus ();

  topk_merge_ctrl #(
    .DATA_WIDTH(DW), .IDX_WIDTH(IW), .NB_WIDTH(NBW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int nb;
    int bd [3][4];
    int bi [3][4];
    int ed [4];
    int ei [4];
    int lat;
  } vec_t;

  vec_t vt [5];
  vec_t cur;
  logic feed_en   = 1'b0;
  logic sorter_on = 1'b1;
  int   bidx      = 0;
  int   n_chk     = 0;
  int   n_err     = 0;
  int   sv_cnt    = 0;
  int   rv_cnt    = 0;

  // Candidate source: presents batch bidx of the current vector
  always_comb begin
    int b;
    b = (bidx < 3) ? bidx : 0;
    bus.cand_valid = feed_en && (bidx < cur.nb);
    for (int k = 0; k < 4; k++) begin
      bus.cand_data[k] = DW'(cur.bd[b][k]);
      bus.cand_idx[k]  = IW'(cur.bi[b][k]);
    end
  end

  always @(posedge clk) begin
    if (bus.start && !bus.busy)                bidx <= 0;
    else if (bus.cand_valid && bus.cand_ready) bidx <= bidx + 1;
  end

  function automatic void sort8(input int din [8], input int iin [8],
                                output int dout [4], output int iout [4]);
    int d [8];
    int x [8];
    int t;
    d = din;
    x = iin;
    for (int p = 0; p < 8; p++)
      for (int q = 0; q < 7 - p; q++)
        if (d[q] > d[q+1] || (d[q] == d[q+1] && x[q] > x[q+1])) begin
          t = d[q]; d[q] = d[q+1]; d[q+1] = t;
          t = x[q]; x[q] = x[q+1]; x[q+1] = t;
        end
    for (int k = 0; k < 4; k++) begin
      dout[k] = d[k];
      iout[k] = x[k];
    end
  endfunction

  int   td [4];
  int   ti [4];
  int   s1_d [4];
  int   s1_i [4];
  int   s2_d [4];
  int   s2_i [4];
  logic s1_v = 1'b0;
  logic s2_v = 1'b0;

  always_comb begin
    int ld [8];
    int li [8];
    for (int k = 0; k < 8; k++) begin
      ld[k] = int'(bus.sort_data_in[k]);
      li[k] = int'(bus.sort_idx_in[k]);
    end
    sort8(ld, li, td, ti);
  end

  always @(posedge clk) begin
    s1_v <= bus.sort_valid_in && sorter_on;
    if (bus.sort_valid_in) begin
      s1_d <= td;
      s1_i <= ti;
    end
    s2_v <= s1_v;
    s2_d <= s1_d;
    s2_i <= s1_i;
  end

  always_comb begin
    bus.sort_valid_out = s2_v;
    for (int k = 0; k < 4; k++) begin
      bus.sort_data_out[k] = DW'(s2_d[k]);
      bus.sort_idx_out[k]  = IW'(s2_i[k]);
    end
  end

  always @(posedge clk) begin
    if (bus.sort_valid_in) sv_cnt <= sv_cnt + 1;
    if (bus.res_valid)     rv_cnt <= rv_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int ed [4], input int ei [4]);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_res_data%0d", tag, k), int'(bus.res_data[k]), ed[k]);
      chk($sformatf("%s_res_idx%0d", tag, k), int'(bus.res_idx[k]), ei[k]);
    end
  endtask

  // Called at a negedge; drives start immediately, returns at the negedge after res_valid
  task automatic run_query(input int v);
    int lat;
    int sv0;
    int rv0;
    bit seen;
    string tag;
    tag = $sformatf("v%0d", v);
    cur = vt[v];
    sv0 = sv_cnt;
    rv0 = rv_cnt;
    feed_en = 1'b1;
    bus.num_batches = NBW'(vt[v].nb);
    bus.start = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.start = 1'b0;
      seen = bus.res_valid;
    end
    chk({tag, "_latency"}, lat, vt[v].lat);
    chk_res(tag, vt[v].ed, vt[v].ei);
    chk({tag, "_sort_pulses"}, sv_cnt - sv0, vt[v].nb);
    @(negedge clk);
    chk({tag, "_res_valid_width"}, int'(bus.res_valid), 0);
    chk({tag, "_busy_after"}, int'(bus.busy), 0);
    chk({tag, "_res_pulses"}, rv_cnt - rv0, 1);
  endtask

  initial begin
    int sv0;
    int rv0;
    int n;
    bit seen;
    int ones [4];
    int zeros [4];
    ones  = '{2047, 2047, 2047, 2047};
    zeros = '{0, 0, 0, 0};

    vt[0].nb = 1;
    vt[0].bd[0] = '{3, 20, 124, 826};   vt[0].bi[0] = '{1, 2, 4, 7};
    vt[0].ed    = '{3, 20, 124, 826};   vt[0].ei    = '{1, 2, 4, 7};
    vt[0].lat   = 6;

    vt[1].nb = 2;
    vt[1].bd[0] = '{3, 20, 124, 826};   vt[1].bi[0] = '{1, 2, 4, 7};
    vt[1].bd[1] = '{0, 125, 83, 283};   vt[1].bi[1] = '{0, 5, 3, 6};
    vt[1].ed    = '{0, 3, 20, 83};      vt[1].ei    = '{0, 1, 2, 3};
    vt[1].lat   = 10;

    vt[2].nb = 0;
    vt[2].ed  = '{2047, 2047, 2047, 2047};
    vt[2].ei  = '{0, 0, 0, 0};
    vt[2].lat = 2;

    vt[3].nb = 2;
    vt[3].bd[0] = '{500, 400, 300, 200}; vt[3].bi[0] = '{10, 11, 12, 13};
    vt[3].bd[1] = '{50, 600, 250, 1};    vt[3].bi[1] = '{20, 21, 22, 23};
    vt[3].ed    = '{1, 50, 200, 250};    vt[3].ei    = '{23, 20, 13, 22};
    vt[3].lat   = 10;

    vt[4].nb = 3;
    vt[4].bd[0] = '{9, 8, 7, 6};         vt[4].bi[0] = '{1, 2, 3, 4};
    vt[4].bd[1] = '{100, 2, 50, 3};      vt[4].bi[1] = '{5, 6, 7, 8};
    vt[4].bd[2] = '{4, 1, 60, 0};        vt[4].bi[2] = '{9, 10, 11, 12};
    vt[4].ed    = '{0, 1, 2, 3};         vt[4].ei    = '{12, 10, 6, 8};
    vt[4].lat   = 14;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.num_batches = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_cand_ready", int'(bus.cand_ready), 0);
    chk("rst_sort_valid_in", int'(bus.sort_valid_in), 0);
    chk("rst_res_valid", int'(bus.res_valid), 0);
    chk("rst_err_timeout", int'(bus.err_timeout), 0);
    chk_res("rst", ones, zeros);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back queries from the vector table
    for (int v = 0; v < 5; v++) run_query(v);

    // Stalled LOAD with a start pulse in the middle of the query
    cur = vt[0];
    feed_en = 1'b0;
    sv0 = sv_cnt;
    rv0 = rv_cnt;
    bus.num_batches = NBW'(1);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.start = (c == 5);
      if (c == 5) bus.num_batches = NBW'(5);
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("stall_sort_pulses", sv_cnt - sv0, 0);
    chk("stall_cand_ready", int'(bus.cand_ready), 1);
    chk("stall_busy", int'(bus.busy), 1);
    feed_en = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = bus.res_valid;
    end
    chk("stall_res_seen", int'(seen), 1);
    chk_res("stall", vt[0].ed, vt[0].ei);
    chk("stall_sort_total", sv_cnt - sv0, 1);
    repeat (3) @(negedge clk);
    chk_res("stall_hold", vt[0].ed, vt[0].ei);
    chk("stall_res_pulses", rv_cnt - rv0, 1);

    // Reset while WAITing on the sorter; its late result must be ignored
    cur = vt[1];
    feed_en = 1'b1;
    rv0 = rv_cnt;
    bus.num_batches = NBW'(2);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    seen = bus.sort_valid_in;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = bus.sort_valid_in;
    end
    chk("rstq_reached_wait", int'(seen), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rstq_busy", int'(bus.busy), 0);
    chk("rstq_cand_ready", int'(bus.cand_ready), 0);
    chk("rstq_sort_valid_in", int'(bus.sort_valid_in), 0);
    chk("rstq_res_pulses", rv_cnt - rv0, 0);
    chk("rstq_err_timeout", int'(bus.err_timeout), 0);
    chk_res("rstq", ones, zeros);
    run_query(0);

`ifdef TOPK_MERGE_TIMEOUT_EN
    cur = vt[0];
    feed_en = 1'b1;
    sorter_on = 1'b0;
    rv0 = rv_cnt;
    bus.num_batches = NBW'(1);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    seen = bus.sort_valid_in;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = bus.sort_valid_in;
    end
    chk("tmo_reached_wait", int'(seen), 1);
    n = 0;
    while (!bus.err_timeout && n < TMO + 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_busy", int'(bus.busy), 0);
    repeat (5) @(negedge clk);
    chk("tmo_sticky", int'(bus.err_timeout), 1);
    chk("tmo_res_pulses", rv_cnt - rv0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("tmo_cleared", int'(bus.err_timeout), 0);
    sorter_on = 1'b1;
    repeat (4) @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
